// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

    // Active-low segment vector, bit 6 = g ... bit 0 = a.
    typedef logic [6:0] seg_t;

    // All segments dark.
    localparam seg_t SEG_OFF = 7'h7F;

    // Hex glyphs, entry 15 first so GLYPH[n] is the glyph for value n.
    localparam seg_t [15:0] GLYPH = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Per-slot phase: anodes dark first, then the digit is shown.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-glyph lookup, active-low segments.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    assign seg = GLYPH[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment driver with per-slot blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [7:0] dig_en,
    input  logic [7:0] dp_en,
    output logic       sa,
    output logic       sb,
    output logic       sc,
    output logic       sd,
    output logic       se,
    output logic       sf,
    output logic       sg,
    output logic       DP,
    output logic [7:0] AN
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    // One extra bit so the blanking limit compares cleanly against cnt.
    localparam logic [CNT_W:0]   BLANK_LIM = (CNT_W + 1)'(BLANK_CYC);
    localparam scan_state_t      RST_STATE = (BLANK_CYC > 0) ? BLANK : SHOW;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    scan_state_t      state_q, state_d;
    logic [3:0]       digit_q [8];

    seg_t             glyph;

    // Values computed from current state, registered onto the pins.
    logic [7:0]       an_p0;
    seg_t             seg_p0;
    logic             dp_p0;
    logic [7:0]       an_p1;
    seg_t             seg_p1;
    logic             dp_p1;

    seg7_hex_decode u_decode (
        .hex (digit_q[idx_q]),
        .seg (glyph)
    );

    // Digit register file; reset clears it and has priority over writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                digit_q[k] <= 4'h0;
            end
        end else if (wr_en) begin
            digit_q[wr_addr] <= wr_data;
        end
    end

    // Slot counter, scan index and FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            state_q <= RST_STATE;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    // Next counter/index; state tracks whether the next cnt is in the blank window.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
        state_d = ({1'b0, cnt_d} < BLANK_LIM) ? BLANK : SHOW;
    end

    // Pin values for the current slot phase; dark unless showing.
    always_comb begin
        an_p0  = 8'hFF;
        seg_p0 = SEG_OFF;
        dp_p0  = 1'b1;
        if (state_q == SHOW) begin
            an_p0  = dig_en[idx_q] ? ~(8'b1 << idx_q) : 8'hFF;
            seg_p0 = glyph;
            dp_p0  = ~dp_en[idx_q];
        end
    end

    // ---- stage p0 -> p1: output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            an_p1  <= 8'hFF;
            seg_p1 <= SEG_OFF;
            dp_p1  <= 1'b1;
        end else begin
            an_p1  <= an_p0;
            seg_p1 <= seg_p0;
            dp_p1  <= dp_p0;
        end
    end

    assign AN = an_p1;
    assign DP = dp_p1;
    assign {sg, sf, se, sd, sc, sb, sa} = seg_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a cycle-count reference model.
module tb_seg7_scan_ctrl;

    localparam int RD = 4;
    localparam int BC = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'd0;
    logic [7:0] dig_en = 8'hFF;
    logic [7:0] dp_en = 8'h00;
    logic       sa, sb, sc, sd, se, sf, sg, DP;
    logic [7:0] AN;
    logic [6:0] seg_obs;

    int tests = 0;
    int failures = 0;

    // Reference model: n = non-reset edges since reset; slot/phase derived arithmetically.
    int         n = 0;
    logic [3:0] mdig [8];
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       timed_out;

    logic [6:0] glyph_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    assign seg_obs = {sg, sf, se, sd, sc, sb, sa};

    seg7_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .dig_en  (dig_en),
        .dp_en   (dp_en),
        .sa      (sa),
        .sb      (sb),
        .sc      (sc),
        .sd      (sd),
        .se      (se),
        .sf      (sf),
        .sg      (sg),
        .DP      (DP),
        .AN      (AN)
    );

    always #5 clk = ~clk;

    // One clock: predict the pins after this edge, advance the model, settle 1 ns past the edge.
    task automatic step(input logic r, input logic we, input logic [2:0] a, input logic [3:0] d);
        int c, k;
        rst = r; wr_en = we; wr_addr = a; wr_data = d;
        if (r) begin
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            c = n % RD;
            k = (n / RD) % 8;
            if (c < BC) begin
                exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an  = dig_en[k] ? ~(8'd1 << k) : 8'hFF;
                exp_seg = glyph_ref[mdig[k]];
                exp_dp  = ~dp_en[k];
            end
        end
        @(posedge clk);
        if (r) begin
            n = 0;
            for (int i = 0; i < 8; i++) mdig[i] = 4'h0;
        end else begin
            n = n + 1;
            if (we) mdig[a] = d;
        end
        #1;
        rst = 1'b0; wr_en = 1'b0;
    endtask

    // Idle until the model's next edge is at the given slot and count.
    task automatic advance_to(input int slot, input int c);
        timed_out = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if ((n % RD) == c && ((n / RD) % 8) == slot) begin
                timed_out = 1'b0;
                break;
            end
            step(1'b0, 1'b0, 3'd0, 4'd0);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0);
            tests++;
            if ({AN, seg_obs, DP} !== {8'hFF, 7'h7F, 1'b1}) begin
                $display("FAIL reset_hold cyc%0d: got AN=%h seg=%b DP=%b, want FF 1111111 1", i, AN, seg_obs, DP);
                failures++;
            end
        end
        step(1'b0, 1'b0, 3'd0, 4'd0);
        tests++;
        if ({AN, seg_obs, DP} !== {8'hFF, 7'h7F, 1'b1}) begin
            $display("FAIL reset_release: got AN=%h seg=%b DP=%b, want FF 1111111 1", AN, seg_obs, DP);
            failures++;
        end
        step(1'b0, 1'b0, 3'd0, 4'd0);
        tests++;
        if ({AN, seg_obs, DP} !== {8'hFE, 7'b1000000, 1'b1}) begin
            $display("FAIL reset_first_show: got AN=%h seg=%b DP=%b, want FE 1000000 1", AN, seg_obs, DP);
            failures++;
        end
    endtask

    task automatic test_full_scan();
        int c, k;
        dig_en = 8'hFF; dp_en = 8'h00;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 4'(i));
        advance_to(0, 0);
        tests++;
        if (timed_out) begin
            $display("FAIL full_scan_align: slot 0 start not reached");
            failures++;
        end
        for (int i = 0; i < 64; i++) begin
            c = n % RD;
            k = (n / RD) % 8;
            step(1'b0, 1'b0, 3'd0, 4'd0);
            tests++;
            if ({AN, seg_obs, DP} !== {exp_an, exp_seg, exp_dp}) begin
                $display("FAIL full_scan slot%0d cnt%0d: got %h %b %b, want %h %b %b",
                         k, c, AN, seg_obs, DP, exp_an, exp_seg, exp_dp);
                failures++;
            end
            if (c != 0 && k == 1) begin
                tests++;
                if ({AN, seg_obs} !== {8'hFD, 7'b1111001}) begin
                    $display("FAIL full_scan_slot1: got AN=%h seg=%b, want FD 1111001", AN, seg_obs);
                    failures++;
                end
            end
            if (c == 0) begin
                tests++;
                if (AN !== 8'hFF) begin
                    $display("FAIL full_scan_blank slot%0d: got AN=%h, want FF", k, AN);
                    failures++;
                end
            end
        end
    endtask

    task automatic test_mask_dp();
        int an_low, dp_low;
        an_low = 0; dp_low = 0;
        dig_en = 8'h05; dp_en = 8'h04;
        advance_to(0, 0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 3'd0, 4'd0);
            tests++;
            if ({AN, seg_obs, DP} !== {exp_an, exp_seg, exp_dp}) begin
                $display("FAIL mask_dp cyc%0d: got %h %b %b, want %h %b %b",
                         i, AN, seg_obs, DP, exp_an, exp_seg, exp_dp);
                failures++;
            end
            if (AN !== 8'hFF) an_low++;
            if (DP === 1'b0) dp_low++;
        end
        tests++;
        if (an_low != 6 || dp_low != 3) begin
            $display("FAIL mask_dp_counts: got an_low=%0d dp_low=%0d, want 6 3", an_low, dp_low);
            failures++;
        end
        dig_en = 8'hFF; dp_en = 8'h00;
    endtask

    task automatic test_live_write();
        advance_to(3, 1);
        step(1'b0, 1'b1, 3'd3, 4'hA);
        tests++;
        if ({AN, seg_obs} !== {8'hF7, 7'b0110000}) begin
            $display("FAIL live_write_before: got AN=%h seg=%b, want F7 0110000", AN, seg_obs);
            failures++;
        end
        step(1'b0, 1'b0, 3'd0, 4'd0);
        tests++;
        if ({AN, seg_obs} !== {8'hF7, 7'b0001000}) begin
            $display("FAIL live_write_after: got AN=%h seg=%b, want F7 0001000", AN, seg_obs);
            failures++;
        end
    endtask

    task automatic test_rollover_write();
        advance_to(3, RD - 1);
        step(1'b0, 1'b1, 3'd4, 4'hE);
        step(1'b0, 1'b0, 3'd0, 4'd0);
        tests++;
        if (AN !== 8'hFF) begin
            $display("FAIL rollover_blank: got AN=%h, want FF", AN);
            failures++;
        end
        step(1'b0, 1'b0, 3'd0, 4'd0);
        tests++;
        if ({AN, seg_obs} !== {8'hEF, 7'b0000110}) begin
            $display("FAIL rollover_write: got AN=%h seg=%b, want EF 0000110", AN, seg_obs);
            failures++;
        end
    endtask

    task automatic test_reset_mid_scan();
        int shown;
        shown = 0;
        advance_to(5, 2);
        step(1'b1, 1'b0, 3'd0, 4'd0);
        tests++;
        if ({AN, seg_obs, DP} !== {8'hFF, 7'h7F, 1'b1}) begin
            $display("FAIL reset_mid: got AN=%h seg=%b DP=%b, want FF 1111111 1", AN, seg_obs, DP);
            failures++;
        end
        step(1'b0, 1'b0, 3'd0, 4'd0);
        step(1'b0, 1'b0, 3'd0, 4'd0);
        tests++;
        if (AN !== 8'hFE) begin
            $display("FAIL reset_mid_slot0: got AN=%h, want FE", AN);
            failures++;
        end
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 3'd0, 4'd0);
            if (AN !== 8'hFF) begin
                shown++;
                tests++;
                if (seg_obs !== 7'b1000000) begin
                    $display("FAIL reset_mid_zero cyc%0d: got seg=%b, want 1000000", i, seg_obs);
                    failures++;
                end
            end
        end
        tests++;
        if (shown != 24) begin
            $display("FAIL reset_mid_shown: got %0d shown cycles, want 24", shown);
            failures++;
        end
    endtask

    task automatic test_random();
        logic       r, we;
        logic [2:0] a;
        logic [3:0] d;
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) begin
                dig_en = 8'($urandom);
                dp_en  = 8'($urandom);
            end
            r  = ($urandom_range(0, 149) == 0);
            we = ($urandom_range(0, 2) == 0);
            a  = 3'($urandom);
            d  = 4'($urandom);
            step(r, we, a, d);
            tests++;
            if ({AN, seg_obs, DP} !== {exp_an, exp_seg, exp_dp}) begin
                $display("FAIL random cyc%0d: got %h %b %b, want %h %b %b",
                         i, AN, seg_obs, DP, exp_an, exp_seg, exp_dp);
                failures++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mdig[i] = 4'h0;
        exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; timed_out = 1'b0;
        #2;
        test_reset();
        test_full_scan();
        test_mask_dp();
        test_live_write();
        test_rollover_write();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller for the board's 8-digit common-anode seven-segment display. It holds eight 4-bit hex digit registers written by upstream logic and sequences them onto the shared segment lines (sa..sg, DP). It rotates the active-low anode select AN one digit per refresh slot. A short blanking interval at the start of each slot suppresses ghosting. It sits between the lab datapath and the display pins, and contains the hex-to-segment decoder as a sub-module.

## Interface
- REFRESH_DIV, default 100000: clocks per digit slot (1 kHz per digit at 100 MHz); legal range is at least BLANK_CYC+2.
- BLANK_CYC, default 1000: clocks at the start of each slot with all anodes off; 0 disables blanking.
- clk  in  1  system clock; the block uses a single clock domain.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the digit register file.
- wr_addr  in  3  digit index to write (0 = rightmost, AN[0]).
- wr_data  in  4  hex value 0..F.
- dig_en  in  8  per-digit display enable, level-sensitive; bit k=0 keeps AN[k] high.
- dp_en  in  8  per-digit decimal point, level-sensitive; bit k=1 drives DP low during slot k.
- sa, sb, sc, sd, se, sf, sg  out  1 each  segment cathodes, active-low, registered.
- DP  out  1  decimal-point cathode, active-low, registered.
- AN  out  8  anode selects, active-low, one-hot-low or all-high, registered.

## Operation
- State: digit[0..7] (4 b each), slot counter cnt (width $clog2(REFRESH_DIV)), scan index idx (3 b), FSM {BLANK, SHOW}.
- cnt counts 0..REFRESH_DIV-1. When cnt==REFRESH_DIV-1, cnt goes to 0 and idx goes to idx+1 mod 8 (wraps 7 to 0).
- FSM state is BLANK while cnt < BLANK_CYC, and SHOW otherwise.
- BLANK_CYC=0 means the FSM never enters BLANK.
- In BLANK: AN=8'hFF, all segments 1, DP=1.
- In SHOW:
  - AN = ~(8'b1<<idx) if dig_en[idx], else 8'hFF.
  - Segments = decode(digit[idx]).
  - DP = ~dp_en[idx].
- A disabled digit still consumes its slot; the scan never skips slots.
- Write: when wr_en is high, digit[wr_addr] <= wr_data on the clock edge. Writes are accepted in every state and every cycle.
- Write to the currently shown digit: the new glyph appears on the pins one cycle after the write edge.
- Write coinciding with a slot rollover: both take effect. The next slot displays the written value if wr_addr matches the new idx.
- Decoder (active-low, segments g..a):
  - 0=7'b1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- All outputs are registered from the current state, so pins lag internal state by exactly one cycle.
- Reset values:
  - Outputs: AN=8'hFF, sa..sg=1, DP=1.
  - Internal: cnt=0, idx=0, digit[*]=0.
- rst has priority over wr_en. Asserting rst mid-scan clears everything on that edge, and the pins show the reset values on the following cycle.
- After rst deasserts, the first cycle has cnt=0 and idx=0 (BLANK if BLANK_CYC>0).
- Slot period is exactly REFRESH_DIV cycles, so the full-frame period is 8*REFRESH_DIV.
- dig_en and dp_en are sampled every cycle; a change shows on the pins one cycle later.

## Structure
- Shared package seg7_pkg holds:
  - the typedef for the 7-bit segment vector,
  - localparam SEG_OFF=7'h7F,
  - the 16-entry glyph constants,
  - the FSM state enum {BLANK, SHOW}.
- Sub-module seg7_hex_decode: combinational, 4-bit in, 7-bit active-low out, uses seg7_pkg.
- The top level contains the register file, counter, FSM and output registers.

## Test plan
All scenarios use REFRESH_DIV=4 and BLANK_CYC=1.
- Reset: hold rst 3 cycles, then release → AN=FF, {sg..sa}=7F and DP=1 during and one cycle after reset.
- Full scan:
  - Stimulus: write digit k=k for k=0..7, dig_en=FF, dp_en=00.
  - Slot k: AN=FF for 1 cycle, then AN=~(1<<k) for 3 cycles. Slot 1 shows 7'b1111001 and slot 0 shows 7'b1000000.
  - After 32 cycles idx wraps to 0 and slot 0 repeats.
- Mask and DP: dig_en=8'h05, dp_en=8'h04 → only AN[0] and AN[2] go low. DP=0 only in slot 2; all other slots keep AN=FF and DP=1.
- Live write: during SHOW of slot 3, write addr 3 = 4'hA → segments become 7'b0001000 on the next cycle while AN stays F7.
- Rollover plus write: write addr 4 = 4'hE on the edge where cnt 3→0 into slot 4 → after blanking, slot 4 shows 7'b0000110.
- Reset mid-scan: pulse rst for one cycle at idx=5 in SHOW → next cycle AN=FF. A subsequent scan shows every digit as "0" (7'b1000000), starting from slot 0.
